// File: rtl/victim_cache_pkg.sv
// rtl/victim_cache_pkg.sv - shared defaults, opcode and controller state types for the victim cache
package victim_cache_pkg;

  localparam int TAG_WIDTH_DEF = 4;
  localparam int NUM_WAYS_DEF  = 4;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } vc_op_e;

  typedef enum logic [3:0] {
    IDLE,
    LKP,
    LKP_CHK,
    INV,
    RD,
    RD_CHK,
    WB,
    WR,
    DTY,
    RESP
  } vc_state_e;

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// rtl/victim_cache_ctrl_if.sv - request/response and writeback handshakes of the victim cache controller
interface victim_cache_ctrl_if #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 req_dirty;

  logic                 resp_valid;
  logic                 resp_hit;
  logic [WAY_W-1:0]     resp_way;

  logic                 wb_valid;
  logic [TAG_WIDTH-1:0] wb_tag;
  logic                 wb_ready;

  // Requester / writeback sink side.
  modport master (
    output req_valid, req_op, req_tag, req_dirty, wb_ready,
    input  req_ready, resp_valid, resp_hit, resp_way, wb_valid, wb_tag
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_tag, req_dirty, wb_ready,
    output req_ready, resp_valid, resp_hit, resp_way, wb_valid, wb_tag
  );

endinterface

// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - victim cache controller sequencing lookups and round-robin inserts
module victim_cache_ctrl
  import victim_cache_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int NUM_WAYS  = NUM_WAYS_DEF,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  victim_cache_ctrl_if.slave   bus,
  output logic                 ts_write_en,
  output logic                 ts_read_en,
  output logic                 ts_lookup_en,
  output logic                 ts_valid_clear,
  output logic                 ts_dirty_set,
  output logic                 ts_dirty_clear,
  output logic [TAG_WIDTH-1:0] ts_tag,
  output logic [WAY_W-1:0]     ts_way,
  input  logic                 ts_hit,
  input  logic [WAY_W-1:0]     ts_hit_way,
  input  logic                 ts_valid_read,
  input  logic                 ts_dirty_read,
  input  logic [TAG_WIDTH-1:0] ts_tag_read
);

  vc_state_e            state, state_n;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 dirty_q;
  logic [WAY_W-1:0]     hit_way_q;
  logic [WAY_W-1:0]     rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tag_q        <= '0;
      dirty_q      <= 1'b0;
      hit_way_q    <= '0;
      rr_ptr       <= '0;
      bus.resp_hit <= 1'b0;
      bus.resp_way <= '0;
      bus.wb_tag   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        tag_q   <= bus.req_tag;
        dirty_q <= bus.req_dirty;
      end
      if (state == LKP_CHK) begin
        hit_way_q <= ts_hit_way;
        if (!ts_hit) begin
          bus.resp_hit <= 1'b0;
          bus.resp_way <= '0;
        end
      end
      if (state == INV) begin
        bus.resp_hit <= 1'b1;
        bus.resp_way <= hit_way_q;
      end
      // Capture the victim tag once so it stays stable however long the sink stalls.
      if (state == RD_CHK && ts_valid_read && ts_dirty_read) begin
        bus.wb_tag <= ts_tag_read;
      end
      if (state == DTY) begin
        bus.resp_hit <= 1'b0;
        bus.resp_way <= rr_ptr;
        rr_ptr       <= rr_ptr + WAY_W'(1);
      end
    end
  end

  always_comb begin
    state_n        = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.wb_valid   = 1'b0;
    ts_write_en    = 1'b0;
    ts_read_en     = 1'b0;
    ts_lookup_en   = 1'b0;
    ts_valid_clear = 1'b0;
    ts_dirty_set   = 1'b0;
    ts_dirty_clear = 1'b0;
    ts_tag         = '0;
    ts_way         = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_n = (vc_op_e'(bus.req_op) == OP_INSERT) ? RD : LKP;
        end
      end
      LKP: begin
        ts_lookup_en = 1'b1;
        ts_tag       = tag_q;
        state_n      = LKP_CHK;
      end
      LKP_CHK: state_n = ts_hit ? INV : RESP;
      // A hit moves the line back into L1, so the victim copy is dropped.
      INV: begin
        ts_valid_clear = 1'b1;
        ts_way         = hit_way_q;
        state_n        = RESP;
      end
      RD: begin
        ts_read_en = 1'b1;
        ts_way     = rr_ptr;
        state_n    = RD_CHK;
      end
      RD_CHK: state_n = (ts_valid_read && ts_dirty_read) ? WB : WR;
      WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          state_n = WR;
        end
      end
      WR: begin
        ts_write_en = 1'b1;
        ts_tag      = tag_q;
        ts_way      = rr_ptr;
        state_n     = DTY;
      end
      DTY: begin
        ts_dirty_set   = dirty_q;
        ts_dirty_clear = !dirty_q;
        ts_way         = rr_ptr;
        state_n        = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb/tb_victim_cache_ctrl.sv - scoreboard bench for victim_cache_ctrl with a behavioural tag store
module tb_victim_cache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  victim_cache_ctrl_if #(.TAG_WIDTH(4), .NUM_WAYS(4)) bus ();

  logic       ts_write_en, ts_read_en, ts_lookup_en;
  logic       ts_valid_clear, ts_dirty_set, ts_dirty_clear;
  logic [3:0] ts_tag;
  logic [1:0] ts_way;
  logic       ts_hit;
  logic [1:0] ts_hit_way;
  logic       ts_valid_read, ts_dirty_read;
  logic [3:0] ts_tag_read;

  victim_cache_ctrl #(.TAG_WIDTH(4), .NUM_WAYS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ts_write_en    (ts_write_en),
    .ts_read_en     (ts_read_en),
    .ts_lookup_en   (ts_lookup_en),
    .ts_valid_clear (ts_valid_clear),
    .ts_dirty_set   (ts_dirty_set),
    .ts_dirty_clear (ts_dirty_clear),
    .ts_tag         (ts_tag),
    .ts_way         (ts_way),
    .ts_hit         (ts_hit),
    .ts_hit_way     (ts_hit_way),
    .ts_valid_read  (ts_valid_read),
    .ts_dirty_read  (ts_dirty_read),
    .ts_tag_read    (ts_tag_read)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tag store answering the strobes one cycle later.
  logic [3:0] m_tag   [4];
  logic       m_valid [4];
  logic       m_dirty [4];
  int         clear_cnt = 0;
  logic [1:0] last_clear_way = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < 4; w++) begin
        m_tag[w]   <= 4'h0;
        m_valid[w] <= 1'b0;
        m_dirty[w] <= 1'b0;
      end
      ts_hit        <= 1'b0;
      ts_hit_way    <= 2'd0;
      ts_valid_read <= 1'b0;
      ts_dirty_read <= 1'b0;
      ts_tag_read   <= 4'h0;
    end else begin
      if (ts_lookup_en) begin
        ts_hit     <= 1'b0;
        ts_hit_way <= 2'd0;
        for (int w = 0; w < 4; w++) begin
          if (m_valid[w] && m_tag[w] == ts_tag) begin
            ts_hit     <= 1'b1;
            ts_hit_way <= 2'(w);
          end
        end
      end
      if (ts_read_en) begin
        ts_valid_read <= m_valid[ts_way];
        ts_dirty_read <= m_dirty[ts_way];
        ts_tag_read   <= m_tag[ts_way];
      end
      if (ts_write_en) begin
        m_tag[ts_way]   <= ts_tag;
        m_valid[ts_way] <= 1'b1;
      end
      if (ts_valid_clear) begin
        m_valid[ts_way] <= 1'b0;
        clear_cnt       <= clear_cnt + 1;
        last_clear_way  <= ts_way;
      end
      if (ts_dirty_set)   m_dirty[ts_way] <= 1'b1;
      if (ts_dirty_clear) m_dirty[ts_way] <= 1'b0;
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    logic       hit;
    logic [1:0] way;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] wb_q[$];
  logic [3:0] r_tag   [4];
  logic       r_valid [4];
  logic       r_dirty [4];
  int         r_rr    = 0;
  int         wb_hold = 0;
  int         wb_wait = 0;
  int         wb_cnt  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: resp_valid with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        if (bus.resp_hit !== e.hit || bus.resp_way !== e.way || (cyc - e.acc) != e.lat) begin
          miscompares++;
          $display("FAIL resp: got hit=%0b way=%0d latency=%0d, expected hit=%0b way=%0d latency=%0d",
                   bus.resp_hit, bus.resp_way, cyc - e.acc, e.hit, e.way, e.lat);
        end
      end
    end
  end

  // Writeback sink: stall wb_hold cycles, then accept and score the victim tag.
  always @(negedge clk) begin
    logic [3:0] t;
    if (!rst && bus.wb_valid) begin
      if (wb_wait >= wb_hold) begin
        bus.wb_ready = 1'b1;
        wb_cnt++;
        vectors++;
        if (wb_q.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected: wb_tag=%h with no writeback predicted", bus.wb_tag);
        end else begin
          t = wb_q.pop_front();
          if (bus.wb_tag !== t) begin
            miscompares++;
            $display("FAIL wb_tag: got %h expected %h", bus.wb_tag, t);
          end
        end
      end else begin
        bus.wb_ready = 1'b0;
        wb_wait++;
      end
    end else begin
      bus.wb_ready = 1'b0;
      wb_wait      = 0;
    end
  end

  logic [5:0] strobes, prev_strobes = 6'd0;
  always @(negedge clk) begin
    strobes = {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear};
    if (strobes != 6'd0) begin
      vectors++;
      if ($countones(strobes) > 1 || (strobes & prev_strobes) != 6'd0) begin
        miscompares++;
        $display("FAIL ts_strobes: got %b after %b, expected one-hot single-cycle", strobes, prev_strobes);
      end
    end
    prev_strobes = strobes;
  end

  task automatic model_reset();
    for (int w = 0; w < 4; w++) begin
      r_tag[w]   = 4'h0;
      r_valid[w] = 1'b0;
      r_dirty[w] = 1'b0;
    end
    r_rr = 0;
    sb_q.delete();
    wb_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input bit op, input logic [3:0] tag, input bit dirty, input bit keep);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_dirty = dirty;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%0b, expected 1 within 200 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    e.hit = 1'b0;
    e.way = 2'd0;
    if (op == 1'b0) begin
      e.lat = 3;
      for (int w = 0; w < 4; w++) begin
        if (r_valid[w] && r_tag[w] == tag) begin
          e.hit      = 1'b1;
          e.way      = 2'(w);
          e.lat      = 4;
          r_valid[w] = 1'b0;
        end
      end
    end else begin
      e.way = 2'(r_rr);
      e.lat = 5;
      if (r_valid[r_rr] && r_dirty[r_rr]) begin
        wb_q.push_back(r_tag[r_rr]);
        e.lat = 6 + wb_hold;
      end
      r_tag[r_rr]   = tag;
      r_valid[r_rr] = 1'b1;
      r_dirty[r_rr] = dirty;
      r_rr          = (r_rr + 1) % 4;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || wb_q.size() != 0 || !bus.req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb_q.size() != 0 || wb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses and %0d writebacks outstanding, expected 0",
               sb_q.size(), wb_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: ready=%b resp_valid=%b wb_valid=%b, expected 1 0 0",
               bus.req_ready, bus.resp_valid, bus.wb_valid);
    end
    vectors++;
    if ({ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear});
    end
    vectors++;
    if (ts_tag !== 4'h0 || ts_way !== 2'd0 || bus.wb_tag !== 4'h0 || bus.resp_hit !== 1'b0 || bus.resp_way !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_operands: ts_tag=%h ts_way=%0d wb_tag=%h resp_hit=%b resp_way=%0d, expected all 0",
               ts_tag, ts_way, bus.wb_tag, bus.resp_hit, bus.resp_way);
    end
    apply_reset();
  endtask

  task automatic test_insert_clean();
    int wb0;
    apply_reset();
    wb0 = wb_cnt;
    do_req(1'b1, 4'hA, 1'b0, 1'b0);
    do_req(1'b1, 4'hB, 1'b0, 1'b0);
    do_req(1'b1, 4'hC, 1'b0, 1'b0);
    wait_done();
    vectors++;
    if (m_tag[0] !== 4'hA || m_tag[1] !== 4'hB || m_tag[2] !== 4'hC || !m_valid[0] || !m_valid[1] || !m_valid[2]) begin
      miscompares++;
      $display("FAIL insert_ways: tags %h %h %h, expected a b c valid", m_tag[0], m_tag[1], m_tag[2]);
    end
    vectors++;
    if (wb_cnt != wb0) begin
      miscompares++;
      $display("FAIL insert_no_wb: %0d writebacks, expected 0", wb_cnt - wb0);
    end
  endtask

  task automatic test_lookup();
    int c0;
    c0 = clear_cnt;
    do_req(1'b0, 4'hB, 1'b0, 1'b0);
    wait_done();
    vectors++;
    if (clear_cnt != c0 + 1 || last_clear_way !== 2'd1) begin
      miscompares++;
      $display("FAIL lookup_invalidate: clears=%0d way=%0d, expected 1 on way 1", clear_cnt - c0, last_clear_way);
    end
    do_req(1'b0, 4'hB, 1'b0, 1'b0);
    wait_done();
    vectors++;
    if (clear_cnt != c0 + 1) begin
      miscompares++;
      $display("FAIL lookup_repeat_clear: clears=%0d expected 1", clear_cnt - c0);
    end
    // Pointer should now sit at 3 after the three inserts.
    do_req(1'b1, 4'h3, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_lookup_fresh();
    int c0;
    apply_reset();
    c0 = clear_cnt;
    do_req(1'b0, 4'hF, 1'b0, 1'b0);
    wait_done();
    vectors++;
    if (clear_cnt != c0) begin
      miscompares++;
      $display("FAIL fresh_miss_clear: clears=%0d expected 0", clear_cnt - c0);
    end
  endtask

  task automatic fill_with_dirty_way0();
    apply_reset();
    wb_hold = 0;
    do_req(1'b1, 4'hA, 1'b1, 1'b0);
    do_req(1'b1, 4'hB, 1'b0, 1'b0);
    do_req(1'b1, 4'hC, 1'b0, 1'b0);
    do_req(1'b1, 4'hE, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_dirty_evict();
    int n;
    fill_with_dirty_way0();
    wb_hold = 3;
    do_req(1'b1, 4'hD, 1'b0, 1'b0);
    n = 0;
    while (!bus.wb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.wb_valid !== 1'b1 || bus.wb_tag !== 4'hA || ts_write_en !== 1'b0) begin
        miscompares++;
        $display("FAIL wb_stall[%0d]: wb_valid=%b wb_tag=%h ts_write_en=%b, expected 1 a 0",
                 i, bus.wb_valid, bus.wb_tag, ts_write_en);
      end
      @(negedge clk);
    end
    wait_done();
    wb_hold = 0;
    vectors++;
    if (m_tag[0] !== 4'hD || m_dirty[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL evict_write: way0 tag=%h dirty=%b, expected d 0", m_tag[0], m_dirty[0]);
    end
    do_req(1'b1, 4'h6, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_reset_in_wb();
    int n;
    fill_with_dirty_way0();
    wb_hold = 5;
    do_req(1'b1, 4'h5, 1'b0, 1'b0);
    n = 0;
    while (!bus.wb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.wb_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_wb: wb_valid=%b resp_valid=%b, expected 0 0", bus.wb_valid, bus.resp_valid);
    end
    model_reset();
    wb_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: req_ready=%b expected 1", bus.req_ready);
    end
    do_req(1'b1, 4'h7, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_req(1'b1, 4'h1, 1'b1, 1'b1);
    do_req(1'b1, 4'h2, 1'b0, 1'b1);
    do_req(1'b0, 4'h1, 1'b0, 1'b1);
    do_req(1'b0, 4'h9, 1'b0, 1'b1);
    do_req(1'b1, 4'h4, 1'b1, 1'b1);
    do_req(1'b0, 4'h2, 1'b0, 1'b0);
    wait_done();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_tag   = 4'h0;
    bus.req_dirty = 1'b0;
    bus.wb_ready  = 1'b0;
    model_reset();
    test_reset();
    test_insert_clean();
    test_lookup();
    test_lookup_fresh();
    test_dirty_evict();
    test_reset_in_wb();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/victim_cache_ctrl.md
VICTIM_CACHE_CTRL -- requirements
Module: victim_cache_ctrl

Interface
REQ-001 Parameter TAG_WIDTH, default 4, tag width in bits.
REQ-002 Parameter NUM_WAYS, default 4, number of victim ways (power of two); WAY_W = $clog2(NUM_WAYS).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  request present; req_ready  out  1  controller can accept.
REQ-007 req_op  in  1  0=LOOKUP (L1 miss probe), 1=INSERT (L1 eviction into victim cache).
REQ-008 req_tag  in  TAG_WIDTH  request tag; req_dirty  in  1  inserted line is dirty (INSERT only).
REQ-009 resp_valid  out  1  one-cycle completion pulse; resp_hit  out  1  LOOKUP hit; resp_way  out  WAY_W  hit way (LOOKUP) or written way (INSERT).
REQ-010 wb_valid  out  1  dirty victim writeback request; wb_tag  out  TAG_WIDTH  victim tag; wb_ready  in  1  downstream accepts.
REQ-011 ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear  out  1 each  tag-store command strobes.
REQ-012 ts_tag  out  TAG_WIDTH; ts_way  out  WAY_W  tag-store operands.
REQ-013 ts_hit  in  1; ts_hit_way  in  WAY_W; ts_valid_read, ts_dirty_read  in  1; ts_tag_read  in  TAG_WIDTH  tag-store results, registered, valid the cycle after the strobe.

Function
REQ-014 States: IDLE, LKP, LKP_CHK, INV, RD, RD_CHK, WB, WR, DTY, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&req_ready at a rising edge; req_tag, req_op, req_dirty latched then.
REQ-016 At most one ts_* strobe SHALL be high in any cycle, each for exactly one cycle.
REQ-017 LOOKUP: IDLE->LKP (ts_lookup_en=1, ts_tag=latched tag)->LKP_CHK (sample ts_hit, ts_hit_way).
REQ-018 LOOKUP hit: LKP_CHK->INV (ts_valid_clear=1, ts_way=hit way; line swaps into L1)->RESP with resp_hit=1, resp_way=hit way; resp_valid 4 cycles after accept.
REQ-019 LOOKUP miss: LKP_CHK->RESP, resp_hit=0, resp_way=0; resp_valid 3 cycles after accept; no invalidate.
REQ-020 INSERT: victim way = round-robin pointer rr_ptr; IDLE->RD (ts_read_en=1, ts_way=rr_ptr)->RD_CHK.
REQ-021 RD_CHK: if ts_valid_read&ts_dirty_read -> WB with wb_tag=ts_tag_read; else -> WR.
REQ-022 WB: wb_valid held 1 and wb_tag stable until wb_ready=1; handshake completes on wb_valid&wb_ready edge -> WR; wb_ready while not in WB ignored.
REQ-023 WR: ts_write_en=1, ts_tag=latched tag, ts_way=rr_ptr (tag store sets valid)->DTY.
REQ-024 DTY: ts_dirty_set=1 if req_dirty else ts_dirty_clear=1, ts_way=rr_ptr ->RESP with resp_hit=0, resp_way=rr_ptr.
REQ-025 rr_ptr SHALL advance by 1 on leaving DTY, wrapping NUM_WAYS-1->0; LOOKUP never changes it.
REQ-026 RESP: resp_valid=1 one cycle -> IDLE; resp_hit/resp_way hold until next RESP.
REQ-027 Clean or invalid victim: INSERT resp_valid 5 cycles after accept; dirty victim adds WB wait cycles (min 1).
REQ-028 Insertion of a tag already present is not checked; caller guarantees uniqueness.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, rr_ptr=0, all ts_* strobes, wb_valid, resp_valid, resp_hit=0, resp_way=0, wb_tag=0, ts_tag=0, ts_way=0.
REQ-030 Reset mid-operation SHALL abort it without completing writeback or response; req_ready=1 first cycle after rst deasserts.

Structure
REQ-031 Shared package victim_cache_pkg SHALL hold TAG_WIDTH/NUM_WAYS defaults, op enum (OP_LOOKUP, OP_INSERT) and the controller state enum.
REQ-032 Single module, no sub-module; tag_store is connected beside it at the victim_cache top level.

Verification
REQ-033 Reset, insert 0xA,0xB,0xC clean -> ways 0,1,2 written, resp_way 0,1,2, no wb_valid, rr_ptr=3.
REQ-034 LOOKUP 0xB -> ts_valid_clear on way 1, resp_hit=1, resp_way=1 at accept+4; repeat LOOKUP 0xB -> resp_hit=0 at accept+3.
REQ-035 LOOKUP 0xF on fresh contents -> resp_hit=0, no ts_valid_clear.
REQ-036 Fill 4 ways with way0=0xA dirty, insert 0xD -> wb_valid with wb_tag=0xA; hold wb_ready=0 for 3 cycles -> wb_valid stays 1, no ts_write_en; then wb_ready=1 -> way0 written 0xD, rr_ptr=1.
REQ-037 Assert rst during WB -> wb_valid=0 same cycle, req_ready=1 after release, rr_ptr=0.
REQ-038 req_valid held high through an operation -> second request accepted only in IDLE, never overlapping ts_* strobes.
